datapath_vector_checker: RTL and testbench
==========================================

Name: datapath_vector_checker

Overview:
- Synthesizable self-check engine for the datapath. It replaces file-driven stimulus and gold comparison with an on-chip vector store.
- Vectors (instruction, data, init-select, expected result) are preloaded through a write port. On start, they are replayed into the datapath one vector every STEP cycles.
- ALUOut is compared with the expected value for every vector whose init-select bit is 1. A mismatch count and the first failure details are kept for the top level or debug bus.

Parameters:
- ISIZE, 16, instruction width
- DSIZE, 16, data / ALUOut / expected width
- DEPTH, 64, vector store entries (power of 2); AW = log2(DEPTH)
- STEP, 2, clk cycles each vector is held (>= 2)
- LAT, 1, cycles from vector applied to ALUOut sample (1 <= LAT <= STEP-1)
- CNTW, 16, error counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- load_en  in  1  write one vector entry this cycle
- load_addr  in  AW  entry index
- load_instr  in  ISIZE  stored instruction
- load_data  in  DSIZE  stored DataInit
- load_initsel  in  1  stored InitSel; 1 = check this vector
- load_exp  in  DSIZE  stored expected ALUOut
- start  in  1  begin run (pulse)
- abort  in  1  stop run immediately
- num_vec  in  AW+1  vectors to run, 0..DEPTH, sampled at start
- stop_on_err  in  1  end run at first mismatch, sampled at start
- ALUOut  in  DSIZE  datapath result
- Instruction  out  ISIZE  to datapath
- DataInit  out  DSIZE  to datapath
- InitSel  out  1  to datapath
- busy  out  1  run in progress
- done  out  1  run completed; held until next start
- pass  out  1  done with err_count == 0
- err_count  out  CNTW  mismatches; saturates at all-ones
- first_err_idx  out  AW  index of first mismatch
- first_err_got  out  DSIZE  ALUOut at first mismatch
- first_err_exp  out  DSIZE  expected value at first mismatch

Behaviour:
- Reset (rst == 0 at a clk edge): all outputs 0, FSM in IDLE. Vector store contents are not reset.
- FSM states:
  - IDLE: start=1 with num_vec > 0 moves to RUN; start=1 with num_vec == 0 moves directly to DONE (pass=1, err_count=0).
  - RUN: applies vectors. Leaves after the last slot, or at the first mismatch when stop_on_err=1.
  - DONE: holds status until the next start.
- Start accepted at edge E0:
  - busy=1 and done=0 from E0.
  - err_count and first_err_* are cleared at E0.
- Vector timing:
  - Vector k drives Instruction, DataInit and InitSel (registered) from edge E1+k*STEP for exactly STEP cycles, where E1 = E0+1.
  - ALUOut is sampled at edge E1+k*STEP+LAT.
- Compare rule:
  - Compare only when the stored initsel bit is 1. Vectors with initsel=0 are applied but never counted.
  - On mismatch, err_count increments at the sample edge.
  - If this is the first mismatch, first_err_idx/got/exp are captured at the same edge.
- End of run, normal: at edge E1+num_vec*STEP, enter DONE. busy=0, done=1, pass=(err_count==0). Instruction, DataInit and InitSel return to 0.
- End of run, stop_on_err: at the sample edge of the first mismatch, enter DONE on that same edge with the same output rules (pass=0).
- start while busy: ignored.
- start in DONE: starts a new run exactly as from IDLE.
- abort while busy: next edge enters IDLE; busy=0, done=0, datapath outputs 0, error status retained. abort has priority over a same-cycle mismatch.
- load_en while busy: ignored. In IDLE or DONE, the write takes effect on the next edge. load_addr >= DEPTH cannot occur (AW bits).
- num_vec > DEPTH is clamped to DEPTH.
- err_count saturation: stays at 2^CNTW-1; further mismatches are not counted.
- Reset mid-run: immediate return to the reset state. The vector store is preserved, so a re-run needs no reload.

Decomposition:
- Shared package/include holds:
  - ISIZE and DSIZE defaults, matching the datapath defines
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - vector record layout, {instr, data, initsel, exp}, width ISIZE+2*DSIZE+1
- One sub-module: vector_store, a DEPTH x record single-write, single-read RAM with registered read.
  - The FSM prefetches entry k+1 during slot k so the outputs switch exactly on slot boundaries.
  - Index, slot and sample counters plus the compare logic stay in the top module.

Test Plan:
- Load 4 vectors, all initsel=1, exp matching a model datapath; STEP=2, LAT=1; start with num_vec=4 -> Instruction changes at E1, E3, E5, E7; done=1 at E9; pass=1; err_count=0.
- Same 4 vectors with exp[2] corrupted to 16'hDEAD, stop_on_err=0 -> err_count=1, first_err_idx=2, first_err_exp=16'hDEAD, all 4 vectors applied, pass=0.
- Corrupt exp[1] and exp[3], stop_on_err=1 -> done asserted at the vector-1 sample edge; err_count=1; vector 2 never driven.
- Vector with initsel=0 and a wrong exp -> no error counted; InitSel output is 0 during its slot; pass=1.
- num_vec=0 start -> done=1 and pass=1 at E1, busy never asserted. Separately, abort at a mid-run slot -> busy=0 and outputs 0 next edge, done=0, and load_en during the run left memory unchanged.
- Reset (rst=0) for one cycle mid-run, then rerun without reload -> identical results to the first run. Forced mismatches beyond 2^CNTW-1 (CNTW=2, 5 errors) -> err_count=2'b11.

Source files
------------

// File: rtl/datapath_vector_checker_pkg.sv
// Shared definitions for the datapath vector checker: default datapath widths,
// FSM state encoding and the packed vector record layout.
package datapath_vector_checker_pkg;

    localparam int unsigned DP_ISIZE = 16;
    localparam int unsigned DP_DSIZE = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Record is packed as {instr, data, initsel, exp}, MSB first.
    function automatic int unsigned rec_width(input int unsigned isize,
                                              input int unsigned dsize);
        return isize + 2 * dsize + 1;
    endfunction

endpackage

// File: rtl/datapath_vector_checker_if.sv
// Stimulus/response bundle between the vector checker (master) and the
// datapath under test (slave).
interface datapath_vector_checker_if
    import datapath_vector_checker_pkg::*;
#(
    parameter int unsigned ISIZE = DP_ISIZE,
    parameter int unsigned DSIZE = DP_DSIZE
);

    logic [ISIZE-1:0] Instruction;
    logic [DSIZE-1:0] DataInit;
    logic             InitSel;
    logic [DSIZE-1:0] ALUOut;

    modport master (
        output Instruction,
        output DataInit,
        output InitSel,
        input  ALUOut
    );

    modport slave (
        input  Instruction,
        input  DataInit,
        input  InitSel,
        output ALUOut
    );

endinterface

// File: rtl/datapath_vector_checker_vector_store.sv
// DEPTH x W vector RAM: one write port, one read port with registered output.
// Contents are intentionally not reset so a run can be repeated after reset.
module datapath_vector_checker_vector_store
    import datapath_vector_checker_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned W     = rec_width(DP_ISIZE, DP_DSIZE)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/datapath_vector_checker.sv
// On-chip self-check engine: replays preloaded vectors into the datapath one
// every STEP cycles and compares ALUOut against the stored expected value.
module datapath_vector_checker
    import datapath_vector_checker_pkg::*;
#(
    parameter  int unsigned ISIZE = DP_ISIZE,
    parameter  int unsigned DSIZE = DP_DSIZE,
    parameter  int unsigned DEPTH = 64,
    parameter  int unsigned STEP  = 2,
    parameter  int unsigned LAT   = 1,
    parameter  int unsigned CNTW  = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_en,
    input  logic [AW-1:0]             load_addr,
    input  logic [ISIZE-1:0]          load_instr,
    input  logic [DSIZE-1:0]          load_data,
    input  logic                      load_initsel,
    input  logic [DSIZE-1:0]          load_exp,
    input  logic                      start,
    input  logic                      abort,
    input  logic [AW:0]               num_vec,
    input  logic                      stop_on_err,
    datapath_vector_checker_if.master dp,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [CNTW-1:0]           err_count,
    output logic [AW-1:0]             first_err_idx,
    output logic [DSIZE-1:0]          first_err_got,
    output logic [DSIZE-1:0]          first_err_exp
);

    localparam int unsigned RW = rec_width(ISIZE, DSIZE);
    localparam int unsigned SW = $clog2(STEP);
    localparam int unsigned NW = AW + 1;

    localparam logic [SW-1:0] SLOT_LAST   = SW'(STEP - 1);
    localparam logic [SW-1:0] SLOT_SAMPLE = SW'(LAT - 1);
    localparam logic [NW-1:0] NUM_MAX     = NW'(DEPTH);

    state_t           state_q, state_d;
    logic [NW-1:0]    num_q, num_d;
    logic             stop_q, stop_d;
    logic [NW-1:0]    nxt_q, nxt_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [AW-1:0]    cur_idx_q, cur_idx_d;
    logic [ISIZE-1:0] instr_q, instr_d;
    logic [DSIZE-1:0] data_q, data_d;
    logic             initsel_q, initsel_d;
    logic [DSIZE-1:0] exp_q, exp_d;
    logic [CNTW-1:0]  err_count_q, err_count_d;
    logic [AW-1:0]    first_idx_q, first_idx_d;
    logic [DSIZE-1:0] first_got_q, first_got_d;
    logic [DSIZE-1:0] first_exp_q, first_exp_d;

    logic             running;
    logic             start_ok;
    logic             mismatch;
    logic             store_we;
    logic [AW-1:0]    rd_addr;
    logic [RW-1:0]    rd_data;
    logic [NW-1:0]    num_clamped;

    logic [ISIZE-1:0] rec_instr;
    logic [DSIZE-1:0] rec_data;
    logic             rec_initsel;
    logic [DSIZE-1:0] rec_exp;

    assign running     = (state_q == ST_RUN);
    assign start_ok    = start && !running;
    assign store_we    = load_en && !running;
    assign num_clamped = (num_vec > NUM_MAX) ? NUM_MAX : num_vec;
    assign mismatch    = running && (slot_q == SLOT_SAMPLE) && initsel_q &&
                         (dp.ALUOut != exp_q);

    // The read port always looks one vector ahead, so the entry for the next
    // slot is already registered when the slot boundary arrives.
    assign rd_addr = start_ok ? '0 : nxt_q[AW-1:0];

    assign rec_instr   = rd_data[RW-1 -: ISIZE];
    assign rec_data    = rd_data[2*DSIZE -: DSIZE];
    assign rec_initsel = rd_data[DSIZE];
    assign rec_exp     = rd_data[DSIZE-1:0];

    datapath_vector_checker_vector_store #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (RW)
    ) u_store (
        .clk     (clk),
        .wr_en   (store_we),
        .wr_addr (load_addr),
        .wr_data ({load_instr, load_data, load_initsel, load_exp}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        stop_d      = stop_q;
        nxt_d       = nxt_q;
        slot_d      = slot_q;
        cur_idx_d   = cur_idx_q;
        instr_d     = instr_q;
        data_d      = data_q;
        initsel_d   = initsel_q;
        exp_d       = exp_q;
        err_count_d = err_count_q;
        first_idx_d = first_idx_q;
        first_got_d = first_got_q;
        first_exp_d = first_exp_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_count_d = '0;
                    first_idx_d = '0;
                    first_got_d = '0;
                    first_exp_d = '0;
                    num_d       = num_clamped;
                    stop_d      = stop_on_err;
                    nxt_d       = '0;
                    // One lead-in cycle lets the first record arrive from the RAM.
                    slot_d      = SLOT_LAST;
                    state_d     = (num_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    instr_d   = '0;
                    data_d    = '0;
                    initsel_d = 1'b0;
                    exp_d     = '0;
                end else begin
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (err_count_q == '0) begin
                            first_idx_d = cur_idx_q;
                            first_got_d = dp.ALUOut;
                            first_exp_d = exp_q;
                        end
                    end
                    if ((mismatch && stop_q) ||
                        ((slot_q == SLOT_LAST) && (nxt_q == num_q))) begin
                        state_d   = ST_DONE;
                        instr_d   = '0;
                        data_d    = '0;
                        initsel_d = 1'b0;
                        exp_d     = '0;
                    end else if (slot_q == SLOT_LAST) begin
                        instr_d   = rec_instr;
                        data_d    = rec_data;
                        initsel_d = rec_initsel;
                        exp_d     = rec_exp;
                        cur_idx_d = nxt_q[AW-1:0];
                        nxt_d     = nxt_q + 1'b1;
                        slot_d    = '0;
                    end else begin
                        slot_d    = slot_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            stop_q      <= 1'b0;
            nxt_q       <= '0;
            slot_q      <= '0;
            cur_idx_q   <= '0;
            instr_q     <= '0;
            data_q      <= '0;
            initsel_q   <= 1'b0;
            exp_q       <= '0;
            err_count_q <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            stop_q      <= stop_d;
            nxt_q       <= nxt_d;
            slot_q      <= slot_d;
            cur_idx_q   <= cur_idx_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            initsel_q   <= initsel_d;
            exp_q       <= exp_d;
            err_count_q <= err_count_d;
            first_idx_q <= first_idx_d;
            first_got_q <= first_got_d;
            first_exp_q <= first_exp_d;
        end
    end

    assign dp.Instruction = instr_q;
    assign dp.DataInit    = data_q;
    assign dp.InitSel     = initsel_q;

    assign busy          = running;
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_count_q == '0);
    assign err_count     = err_count_q;
    assign first_err_idx = first_idx_q;
    assign first_err_got = first_got_q;
    assign first_err_exp = first_exp_q;

endmodule

// File: tb/tb_datapath_vector_checker.sv
// Directed bench for datapath_vector_checker; the modelled datapath computes
// ALUOut = Instruction + DataInit combinationally.
module tb_datapath_vector_checker;

    localparam int unsigned ISIZE = 16;
    localparam int unsigned DSIZE = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CNTW  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_en = 1'b0;
    logic [AW-1:0]    load_addr = '0;
    logic [ISIZE-1:0] load_instr = '0;
    logic [DSIZE-1:0] load_data = '0;
    logic             load_initsel = 1'b0;
    logic [DSIZE-1:0] load_exp = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [AW:0]      num_vec = '0;
    logic             stop_on_err = 1'b0;
    logic             busy, done, pass;
    logic [CNTW-1:0]  err_count;
    logic [AW-1:0]    first_err_idx;
    logic [DSIZE-1:0] first_err_got, first_err_exp;

    logic [ISIZE-1:0] tab_instr [DEPTH];
    logic [DSIZE-1:0] tab_data  [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    int         cyc;
    logic [7:0] seen, sel;

    datapath_vector_checker_if #(.ISIZE(ISIZE), .DSIZE(DSIZE)) dpif ();

    assign dpif.ALUOut = dpif.Instruction + dpif.DataInit;

    datapath_vector_checker #(
        .ISIZE (ISIZE),
        .DSIZE (DSIZE),
        .DEPTH (DEPTH),
        .STEP  (2),
        .LAT   (1),
        .CNTW  (CNTW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_instr    (load_instr),
        .load_data     (load_data),
        .load_initsel  (load_initsel),
        .load_exp      (load_exp),
        .start         (start),
        .abort         (abort),
        .num_vec       (num_vec),
        .stop_on_err   (stop_on_err),
        .dp            (dpif),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic load(input int unsigned a, input logic [15:0] ins, input logic [15:0] dat,
                        input logic isel, input logic [15:0] ex);
        load_en      = 1'b1;
        load_addr    = AW'(a);
        load_instr   = ins;
        load_data    = dat;
        load_initsel = isel;
        load_exp     = ex;
        step();
        load_en      = 1'b0;
        tab_instr[a] = ins;
        tab_data[a]  = dat;
    endtask

    // Start a run and step until done (bounded). cyc = edges after the start
    // edge at which done was first seen, -1 on timeout.
    task automatic run(input logic [AW:0] n, input logic s, output int c_done,
                       output logic [7:0] v_seen, output logic [7:0] v_sel);
        num_vec     = n;
        stop_on_err = s;
        start       = 1'b1;
        step();
        start       = 1'b0;
        c_done      = done ? 0 : -1;
        v_seen      = '0;
        v_sel       = '0;
        for (int c = 1; c <= 200 && c_done < 0; c++) begin
            step();
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (dpif.Instruction == tab_instr[i]) begin
                    v_seen[i] = 1'b1;
                    v_sel[i]  = dpif.InitSel;
                end
            end
            if (done) c_done = c;
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_instr", 32'(dpif.Instruction), 0);
        chk("rst_initsel", 32'(dpif.InitSel), 0);
        chk("rst_fidx", 32'(first_err_idx), 0);
        rst = 1'b1;
        step();

        load(0, 16'h0001, 16'h0010, 1'b1, 16'h0011);
        load(1, 16'h1200, 16'h0034, 1'b1, 16'h1234);
        load(2, 16'hFFFF, 16'h0002, 1'b1, 16'h0001);
        load(3, 16'hA5A5, 16'h5A5A, 1'b1, 16'hFFFF);
        load(4, 16'h0100, 16'h0001, 1'b1, 16'h0101);
        load(5, 16'h2000, 16'h2000, 1'b1, 16'h4000);
        load(6, 16'h0003, 16'h0004, 1'b1, 16'h0007);
        load(7, 16'h8000, 16'h8000, 1'b1, 16'h0000);

        // Basic run, edge by edge: vectors switch at E1, E3, E5, E7; done at E9.
        num_vec = 4; stop_on_err = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_e0_busy", 32'(busy), 1);
        chk("t1_e0_done", 32'(done), 0);
        chk("t1_e0_instr", 32'(dpif.Instruction), 0);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c <= 8) begin
                chk($sformatf("t1_e%0d_instr", c), 32'(dpif.Instruction), 32'(tab_instr[(c-1)/2]));
                chk($sformatf("t1_e%0d_data", c), 32'(dpif.DataInit), 32'(tab_data[(c-1)/2]));
                chk($sformatf("t1_e%0d_sel", c), 32'(dpif.InitSel), 1);
                chk($sformatf("t1_e%0d_busy", c), 32'(busy), 1);
            end else begin
                chk("t1_e9_done", 32'(done), 1);
                chk("t1_e9_busy", 32'(busy), 0);
                chk("t1_e9_pass", 32'(pass), 1);
                chk("t1_e9_err", 32'(err_count), 0);
                chk("t1_e9_instr", 32'(dpif.Instruction), 0);
                chk("t1_e9_sel", 32'(dpif.InitSel), 0);
            end
        end

        // One corrupted expected value, no stop.
        load(2, 16'hFFFF, 16'h0002, 1'b1, 16'hDEAD);
        run(4, 1'b0, cyc, seen, sel);
        chk("t2_cycles", 32'(cyc), 9);
        chk("t2_err", 32'(err_count), 1);
        chk("t2_fidx", 32'(first_err_idx), 2);
        chk("t2_fgot", 32'(first_err_got), 32'h0001);
        chk("t2_fexp", 32'(first_err_exp), 32'hDEAD);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_seen", 32'(seen), 32'h0F);

        // Two corrupted, stop at the first: done at the vector-1 sample edge E4.
        load(2, 16'hFFFF, 16'h0002, 1'b1, 16'h0001);
        load(1, 16'h1200, 16'h0034, 1'b1, 16'hBEEF);
        load(3, 16'hA5A5, 16'h5A5A, 1'b1, 16'hCAFE);
        run(4, 1'b1, cyc, seen, sel);
        chk("t3_cycles", 32'(cyc), 4);
        chk("t3_err", 32'(err_count), 1);
        chk("t3_fidx", 32'(first_err_idx), 1);
        chk("t3_fgot", 32'(first_err_got), 32'h1234);
        chk("t3_fexp", 32'(first_err_exp), 32'hBEEF);
        chk("t3_pass", 32'(pass), 0);
        chk("t3_seen", 32'(seen), 32'h03);
        chk("t3_instr", 32'(dpif.Instruction), 0);

        // Zero-length run from DONE: straight to done with cleared status.
        num_vec = 0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_pass", 32'(pass), 1);
        chk("t4_err", 32'(err_count), 0);
        chk("t4_fexp", 32'(first_err_exp), 0);
        step();
        chk("t4_e1_done", 32'(done), 1);
        chk("t4_e1_busy", 32'(busy), 0);

        // Unchecked vector with a wrong expected value.
        load(1, 16'h1200, 16'h0034, 1'b0, 16'h0BAD);
        load(3, 16'hA5A5, 16'h5A5A, 1'b1, 16'hFFFF);
        run(4, 1'b0, cyc, seen, sel);
        chk("t5_cycles", 32'(cyc), 9);
        chk("t5_err", 32'(err_count), 0);
        chk("t5_pass", 32'(pass), 1);
        chk("t5_seen", 32'(seen), 32'h0F);
        chk("t5_sel", 32'(sel), 32'h0D);

        // Abort on the vector-1 sample edge, which would also mismatch.
        load(0, 16'h0001, 16'h0010, 1'b1, 16'h0BAD);
        load(1, 16'h1200, 16'h0034, 1'b1, 16'hBEEF);
        num_vec = 4; stop_on_err = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        load_en = 1'b1; load_addr = 3'd2; load_instr = 16'h7777;
        load_data = '0; load_initsel = 1'b1; load_exp = '0;
        step();
        load_en = 1'b0;
        chk("t6_e2_err", 32'(err_count), 1);
        chk("t6_e2_fidx", 32'(first_err_idx), 0);
        chk("t6_e2_fgot", 32'(first_err_got), 32'h0011);
        chk("t6_e2_busy", 32'(busy), 1);
        step();
        chk("t6_e3_instr", 32'(dpif.Instruction), 32'h1200);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_pass", 32'(pass), 0);
        chk("t6_instr", 32'(dpif.Instruction), 0);
        chk("t6_data", 32'(dpif.DataInit), 0);
        chk("t6_sel", 32'(dpif.InitSel), 0);
        chk("t6_err", 32'(err_count), 1);
        chk("t6_fexp", 32'(first_err_exp), 32'h0BAD);
        step();
        chk("t6_idle_busy", 32'(busy), 0);

        // num_vec beyond DEPTH clamps to 8 vectors; slot 2 must be unchanged.
        load(0, 16'h0001, 16'h0010, 1'b1, 16'h0011);
        load(1, 16'h1200, 16'h0034, 1'b1, 16'h1234);
        run(15, 1'b0, cyc, seen, sel);
        chk("t7_cycles", 32'(cyc), 17);
        chk("t7_err", 32'(err_count), 0);
        chk("t7_pass", 32'(pass), 1);
        chk("t7_seen", 32'(seen), 32'hFF);
        chk("t7_sel", 32'(sel), 32'hFF);

        // Reset mid-run, then rerun with no reload.
        load(2, 16'hFFFF, 16'h0002, 1'b1, 16'hDEAD);
        num_vec = 4; stop_on_err = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) step();
        chk("t8_pre_err", 32'(err_count), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t8_rst_busy", 32'(busy), 0);
        chk("t8_rst_done", 32'(done), 0);
        chk("t8_rst_err", 32'(err_count), 0);
        chk("t8_rst_instr", 32'(dpif.Instruction), 0);
        chk("t8_rst_fexp", 32'(first_err_exp), 0);
        step();
        run(4, 1'b0, cyc, seen, sel);
        chk("t8_cycles", 32'(cyc), 9);
        chk("t8_err", 32'(err_count), 1);
        chk("t8_fidx", 32'(first_err_idx), 2);
        chk("t8_fgot", 32'(first_err_got), 32'h0001);
        chk("t8_fexp", 32'(first_err_exp), 32'hDEAD);
        chk("t8_pass", 32'(pass), 0);

        // Five mismatches saturate a 2-bit counter at 3.
        load(0, 16'h0001, 16'h0010, 1'b1, 16'hEEEE);
        load(1, 16'h1200, 16'h0034, 1'b1, 16'hEEEE);
        load(2, 16'hFFFF, 16'h0002, 1'b1, 16'hEEEE);
        load(3, 16'hA5A5, 16'h5A5A, 1'b1, 16'hEEEE);
        load(4, 16'h0100, 16'h0001, 1'b1, 16'hEEEE);
        run(5, 1'b0, cyc, seen, sel);
        chk("t9_cycles", 32'(cyc), 11);
        chk("t9_err", 32'(err_count), 3);
        chk("t9_fidx", 32'(first_err_idx), 0);
        chk("t9_fgot", 32'(first_err_got), 32'h0011);
        chk("t9_fexp", 32'(first_err_exp), 32'hEEEE);
        chk("t9_pass", 32'(pass), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
